page_tbl_arbiter: RTL and testbench

Single-port arbiter for one stage's VLAN page table (16-bit × 32-entry RAM). It shares the RAM between NUM_REQ VLAN lookup requesters and the control-path configuration writer. The block grants at most one access per cycle, drives the RAM port, and returns each read result to the requester that issued it. It sits between the lookup/VLAN FIFO side of the action engine and the page table, replacing the fixed dual-port wiring.

---
 rtl/page_tbl_arbiter.sv | 136 +++++++++++++
 tb/tb_page_tbl_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/page_tbl_arbiter.sv
// Single-port page table arbiter: one RAM access per cycle, shared between
// round-robin VLAN read requesters and the configuration writer.
module page_tbl_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int C_VLANID_WIDTH = 12,
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 16,
    parameter int WR_BURST_MAX   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                rd_req_valid,
    input  logic [NUM_REQ*C_VLANID_WIDTH-1:0] rd_req_vlan,
    output logic [NUM_REQ-1:0]                rd_req_ready,
    output logic [DATA_W-1:0]                 rd_rsp_data,
    output logic [NUM_REQ-1:0]                rd_rsp_valid,
    input  logic                              wr_req_valid,
    input  logic [7:0]                        wr_req_addr,
    input  logic [DATA_W-1:0]                 wr_req_data,
    output logic                              wr_req_ready,
    output logic                              ram_en,
    output logic                              ram_we,
    output logic [ADDR_W-1:0]                 ram_addr,
    output logic [DATA_W-1:0]                 ram_din,
    input  logic [DATA_W-1:0]                 ram_dout
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(WR_BURST_MAX + 1);

    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]          wr_burst_cnt_q, wr_burst_cnt_d;
    logic [NUM_REQ-1:0]        tag1_q, tag2_q, rsp_valid_q;
    logic [DATA_W-1:0]         rsp_data_q, rsp_data_d;
    logic                      ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]         ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]         ram_din_q, ram_din_d;

    logic                      any_rd, burst_full, wr_gnt, rd_found, rd_gnt;
    logic [PTR_W-1:0]          rd_idx, cand;
    logic [NUM_REQ-1:0]        rd_gnt_vec;
    logic [C_VLANID_WIDTH-1:0] rd_vlan;
    logic                      unused_bits;

    // Handshake: a transfer happens in the cycle where valid & ready are both
    // high; ready is a combinational function of valid and is one-hot overall.
    always_comb begin
        any_rd     = |rd_req_valid;
        burst_full = (wr_burst_cnt_q == CNT_W'(WR_BURST_MAX));
        wr_gnt     = wr_req_valid && !(burst_full && any_rd);
        rd_found   = 1'b0;
        rd_idx     = rr_ptr_q;
        cand       = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rd_found && rd_req_valid[cand]) begin
                rd_found = 1'b1;
                rd_idx   = cand;
            end
            cand = (cand == PTR_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
        end
        rd_gnt     = rd_found && !wr_gnt;
        rd_gnt_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_gnt_vec[i] = rd_gnt && (rd_idx == PTR_W'(i));
        end
        rd_vlan = rd_req_vlan[rd_idx*C_VLANID_WIDTH +: C_VLANID_WIDTH];
    end

    always_comb begin
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        if (wr_gnt) begin
            ram_en_d   = 1'b1;
            ram_we_d   = 1'b1;
            ram_addr_d = wr_req_addr[ADDR_W-1:0];
            ram_din_d  = wr_req_data;
        end else if (rd_gnt) begin
            ram_en_d   = 1'b1;
            ram_addr_d = rd_vlan[4 +: ADDR_W];
        end

        rr_ptr_d = rr_ptr_q;
        if (rd_gnt) begin
            rr_ptr_d = (rd_idx == PTR_W'(NUM_REQ - 1)) ? '0 : rd_idx + 1'b1;
        end

        // Counts writes that overtook a waiting read; a full count forces a read.
        wr_burst_cnt_d = wr_burst_cnt_q;
        if (rd_gnt || !any_rd) begin
            wr_burst_cnt_d = '0;
        end else if (wr_gnt && !burst_full) begin
            wr_burst_cnt_d = wr_burst_cnt_q + 1'b1;
        end

        rsp_data_d = (|tag2_q) ? ram_dout : rsp_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            wr_burst_cnt_q <= '0;
            tag1_q         <= '0;
            tag2_q         <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            ram_en_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_din_q      <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            wr_burst_cnt_q <= wr_burst_cnt_d;
            tag1_q         <= rd_gnt_vec;
            tag2_q         <= tag1_q;
            rsp_valid_q    <= tag2_q;
            rsp_data_q     <= rsp_data_d;
            ram_en_q       <= ram_en_d;
            ram_we_q       <= ram_we_d;
            ram_addr_q     <= ram_addr_d;
            ram_din_q      <= ram_din_d;
        end
    end

    assign rd_req_ready = rst_n ? rd_gnt_vec : '0;
    assign wr_req_ready = rst_n && wr_gnt;
    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_data  = rsp_data_q;
    assign ram_en       = ram_en_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_din      = ram_din_q;

    // Upper control-index bits and non-address VLAN bits are intentionally ignored.
    assign unused_bits  = ^{wr_req_addr, rd_vlan};
endmodule

// File: tb/tb_page_tbl_arbiter.sv
// Directed and randomized bench for page_tbl_arbiter with a behavioural model
// of the arbitration rules and a small synchronous RAM for the page table.
module tb_page_tbl_arbiter;
    localparam int NUM_REQ = 2;
    localparam int VW      = 12;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 16;
    localparam int WBM     = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    rd_req_valid = '0;
    logic [NUM_REQ*VW-1:0] rd_req_vlan = '0;
    logic [NUM_REQ-1:0]    rd_req_ready;
    logic [DATA_W-1:0]     rd_rsp_data;
    logic [NUM_REQ-1:0]    rd_rsp_valid;
    logic                  wr_req_valid = 1'b0;
    logic [7:0]            wr_req_addr = '0;
    logic [DATA_W-1:0]     wr_req_data = '0;
    logic                  wr_req_ready;
    logic                  ram_en, ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_din;
    logic [DATA_W-1:0]     ram_dout;
    logic [DATA_W-1:0]     ram_mem [32];

    page_tbl_arbiter #(
        .NUM_REQ(NUM_REQ), .C_VLANID_WIDTH(VW), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .WR_BURST_MAX(WBM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid(rd_req_valid), .rd_req_vlan(rd_req_vlan),
        .rd_req_ready(rd_req_ready), .rd_rsp_data(rd_rsp_data),
        .rd_rsp_valid(rd_rsp_valid), .wr_req_valid(wr_req_valid),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_req_ready(wr_req_ready), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // clock / reset block
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_din;
            else        ram_dout <= ram_mem[ram_addr];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    int                 m_ptr, m_burst;
    logic [DATA_W-1:0]  m_mem [32];
    logic               e_en, e_we;
    logic [ADDR_W-1:0]  e_addr;
    logic [DATA_W-1:0]  e_din, e_rsp_data;
    int                 due_q[$];
    logic [NUM_REQ-1:0] tag_q[$];
    logic [DATA_W-1:0]  exp_q[$];
    int                 last_w, last_r;
    logic [NUM_REQ-1:0] obs_rdy;
    logic               obs_wr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_ptr = 0; m_burst = 0;
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0; e_rsp_data = '0;
        due_q.delete(); tag_q.delete(); exp_q.delete();
        last_w = 0; last_r = -1;
    endtask

    // One clock cycle: check the DUT at the falling edge, advance the model.
    task automatic step();
        int                 gw, gr, anyr;
        logic [NUM_REQ-1:0] exp_rdy, t;
        logic [VW-1:0]      vl;
        logic [ADDR_W-1:0]  a;
        @(negedge clk);
        cyc++;
        anyr = (rd_req_valid != '0) ? 1 : 0;
        gw = 0; gr = -1;
        if (wr_req_valid && !(anyr == 1 && m_burst == WBM)) gw = 1;
        else if (anyr == 1) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (m_ptr + k) % NUM_REQ;
                if (gr < 0 && rd_req_valid[i]) gr = i;
            end
        end
        exp_rdy = '0;
        if (gr >= 0) exp_rdy[gr] = 1'b1;
        obs_rdy = rd_req_ready;
        obs_wr  = wr_req_ready;
        chk("rd_req_ready", rd_req_ready, exp_rdy);
        chk("wr_req_ready", wr_req_ready, gw[0]);
        chk("ram_en", ram_en, e_en);
        chk("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_din", ram_din, e_din);
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            t = tag_q.pop_front();
            e_rsp_data = exp_q.pop_front();
            chk("rd_rsp_valid", rd_rsp_valid, t);
        end else begin
            chk("rd_rsp_valid_idle", rd_rsp_valid, '0);
        end
        chk("rd_rsp_data", rd_rsp_data, e_rsp_data);

        if (gw == 1) begin
            m_mem[wr_req_addr[4:0]] = wr_req_data;
            e_en = 1'b1; e_we = 1'b1; e_addr = wr_req_addr[4:0]; e_din = wr_req_data;
        end else if (gr >= 0) begin
            vl = rd_req_vlan[gr*VW +: VW];
            a  = vl[8:4];
            e_en = 1'b1; e_we = 1'b0; e_addr = a;
            due_q.push_back(cyc + 3);
            tag_q.push_back(exp_rdy);
            exp_q.push_back(m_mem[a]);
            m_ptr = (gr + 1) % NUM_REQ;
        end else begin
            e_en = 1'b0; e_we = 1'b0;
        end
        if (gr >= 0 || anyr == 0) m_burst = 0;
        else if (gw == 1 && m_burst < WBM) m_burst = m_burst + 1;
        last_w = gw; last_r = gr;
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic do_write(input logic [7:0] a, input logic [DATA_W-1:0] d);
        int n;
        wr_req_valid = 1'b1; wr_req_addr = a; wr_req_data = d;
        n = 0;
        do begin step(); n++; end while (last_w == 0 && n < 20);
        if (last_w == 0) begin
            total++; bad++;
            $error("FAIL wr_timeout got=%0d exp=1", last_w);
        end
        wr_req_valid = 1'b0;
    endtask

    task automatic do_read(input int i, input logic [VW-1:0] vl, output int n);
        rd_req_valid[i] = 1'b1;
        rd_req_vlan[i*VW +: VW] = vl;
        n = 0;
        do begin step(); n++; end while (last_r != i && n < 20);
        if (last_r != i) begin
            total++; bad++;
            $error("FAIL rd_timeout got=%0d exp=%0d", last_r, i);
        end
        rd_req_valid[i] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ri;
        logic [VW-1:0] vl;
        m_reset();

        // reset values, readies held low even with requests pending
        rd_req_valid = 2'b11; wr_req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_ready", rd_req_ready, '0);
        chk("rst_wr_ready", wr_req_ready, 1'b0);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, '0);
        chk("rst_ram_din", ram_din, '0);
        chk("rst_rsp_valid", rd_rsp_valid, '0);
        chk("rst_rsp_data", rd_rsp_data, '0);
        rd_req_valid = '0; wr_req_valid = 1'b0;
        rst_n = 1'b1;

        // idle bus
        repeat (3) step();
        chk("idle_ram_en", ram_en, 1'b0);
        chk("idle_rsp_valid", rd_rsp_valid, '0);

        // single write then read of the same entry
        do_write(8'd3, 16'hA5A5);
        chk("w1_ram_en", ram_en, 1'b1);
        chk("w1_ram_we", ram_we, 1'b1);
        chk("w1_ram_addr", ram_addr, 5'd3);
        chk("w1_ram_din", ram_din, 16'hA5A5);
        do_read(0, 12'h030, n);
        chk("r1_same_cycle", n, 1);
        step();
        step();
        chk("r1_rsp_valid", rd_rsp_valid, 2'b01);
        chk("r1_rsp_data", rd_rsp_data, 16'hA5A5);
        step();

        // fill the table with data = index, then read it all back
        for (int a = 0; a < 32; a++) do_write(8'(a), DATA_W'(a));
        for (int a = 0; a < 32; a++) begin
            vl = VW'(($urandom_range(0, 7) << 9) | (a << 4) | $urandom_range(0, 15));
            do_read(a % 2, vl, n);
        end
        do_read(1, 12'h1F0, n);
        chk("wrap_addr31", ram_addr, 5'd31);
        do_read(0, 12'h000, n);
        chk("wrap_addr0", ram_addr, 5'd0);
        repeat (4) step();
        chk("drain_ram_en", ram_en, 1'b0);
        chk("drain_rsp_valid", rd_rsp_valid, '0);
        do_read(1, 12'h050, n);
        chk("after_idle_lat", n, 1);
        repeat (4) step();

        // both requesters continuously valid; pointer now at req0
        rd_req_vlan = {12'h090, 12'h050};
        rd_req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("alt_grant", obs_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        rd_req_valid = '0;
        repeat (4) step();

        // write burst against a waiting read from req1
        rd_req_vlan[VW +: VW] = 12'h070;
        rd_req_valid = 2'b10;
        wr_req_valid = 1'b1;
        wr_req_addr = 8'($urandom); wr_req_data = DATA_W'($urandom);
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 4 || k == 9) begin
                chk("burst_rd", obs_rdy, 2'b10);
                chk("burst_rd_nowr", obs_wr, 1'b0);
            end else begin
                chk("burst_wr", obs_wr, 1'b1);
                chk("burst_wr_nord", obs_rdy, 2'b00);
            end
            if (last_w == 1) begin
                wr_req_addr = 8'($urandom); wr_req_data = DATA_W'($urandom);
            end
        end
        wr_req_valid = 1'b0; rd_req_valid = '0;
        repeat (4) step();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!rd_req_valid[i] && $urandom_range(0, 1) == 1) begin
                    rd_req_valid[i] = 1'b1;
                    rd_req_vlan[i*VW +: VW] = VW'($urandom);
                end
            end
            if (!wr_req_valid && $urandom_range(0, 2) == 0) begin
                wr_req_valid = 1'b1;
                wr_req_addr = 8'($urandom);
                wr_req_data = DATA_W'($urandom);
            end
            step();
            if (last_r >= 0) rd_req_valid[last_r] = 1'b0;
            if (last_w == 1) wr_req_valid = 1'b0;
        end
        rd_req_valid = '0; wr_req_valid = 1'b0;
        repeat (4) step();

        // reset with two reads in flight
        rd_req_vlan = {12'h0A0, 12'h0B0};
        rd_req_valid = 2'b11;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_ready", rd_req_ready, '0);
        chk("mid_rst_wr_ready", wr_req_ready, 1'b0);
        chk("mid_rst_ram_en", ram_en, 1'b0);
        chk("mid_rst_ram_we", ram_we, 1'b0);
        chk("mid_rst_ram_addr", ram_addr, '0);
        chk("mid_rst_ram_din", ram_din, '0);
        chk("mid_rst_rsp_valid", rd_rsp_valid, '0);
        chk("mid_rst_rsp_data", rd_rsp_data, '0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_first_grant", obs_rdy, 2'b01);
        ri = last_r;
        if (ri >= 0) rd_req_valid[ri] = 1'b0;
        rd_req_valid = '0;
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
